// File: rtl/freqdiv_monitor_if.sv
// freqdiv_monitor_if: control inputs and measurement results exchanged with freqdiv_monitor
interface freqdiv_monitor_if #(parameter int CNT_W = 16);
  logic en, clear, clk_div;
  logic [CNT_W-1:0] period, high;
  logic meas_stb, valid, locked, timeout;
  modport master(output en, clear, clk_div, input period, high, meas_stb, valid, locked, timeout);
  modport slave(input en, clear, clk_div, output period, high, meas_stb, valid, locked, timeout);
endinterface

// File: rtl/freqdiv_monitor.sv
// freqdiv_monitor: syncs an async divided clock, measures period/high time, flags lock and timeout
module freqdiv_monitor #(
  parameter int CNT_W = 16,
  parameter int LOCK_CNT = 4,
  parameter int TOL = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic wb_clk_i,
  input logic wb_rst_ni,
  freqdiv_monitor_if.slave m
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W:0] TOL_V = (CNT_W + 1)'(TOL);
  localparam logic [MW-1:0] LOCK = MW'(LOCK_CNT);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE, TIMEOUT} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic p, s, rise, fall, take, tmo;
  logic [CNT_W-1:0] pcnt, hlat;
  logic [CNT_W:0] diff;
  logic [MW-1:0] match, match_nxt;
  assign s = sync[SYNC_STAGES-1];
  assign rise = s & ~p;
  assign fall = ~s & p;
  assign take = state == MEASURE && rise;
  assign tmo = state == MEASURE && !rise && pcnt == MAX;
  assign diff = pcnt >= m.period ? {1'b0, pcnt} - {1'b0, m.period} : {1'b0, m.period} - {1'b0, pcnt};
  always_comb begin
    match_nxt = (!m.valid || diff > TOL_V) ? '0 : match == LOCK ? LOCK : match + 1'b1;
    state_nxt = !m.en ? IDLE : (m.clear || state == IDLE) ? ARM : (state != MEASURE && rise) ? MEASURE : tmo ? TIMEOUT : state;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) {sync, p} <= '0;
    else {sync, p} <= {sync[SYNC_STAGES-2:0], m.clk_div, s};
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      {pcnt, hlat, match} <= '0;
      {m.period, m.high, m.meas_stb, m.valid, m.locked, m.timeout} <= '0;
    end else if (!m.en || m.clear) begin
      {pcnt, hlat, match} <= '0;
      {m.period, m.high, m.meas_stb, m.valid, m.locked, m.timeout} <= '0;
    end else begin
      m.meas_stb <= take;
      if ((state == ARM || state == TIMEOUT) && rise) pcnt <= ONE;
      if (state == MEASURE) begin
        if (fall) hlat <= pcnt;
        if (rise) begin
          m.period <= pcnt;
          m.high <= hlat;
          m.valid <= 1'b1;
          m.locked <= match_nxt == LOCK;
          match <= match_nxt;
          pcnt <= ONE;
        end else if (tmo) begin
          m.timeout <= 1'b1;
          m.valid <= 1'b0;
          m.locked <= 1'b0;
          match <= '0;
        end else pcnt <= pcnt + 1'b1;
      end
    end
endmodule

// File: tb/tb_freqdiv_monitor.sv
// tb_freqdiv_monitor: directed and random divided-clock patterns checked against an edge-time model
module tb_freqdiv_monitor;
  localparam int CNT_W = 8, LOCK_CNT = 4, TOL = 1, SS = 2;
  logic clk = 0, rst_n = 0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  int exp_p[$], exp_h[$], exp_t[$], hist[$];
  bit exp_l[$];
  int last_rise = 0, last_fall = 0;
  bit have_rise = 0;
  freqdiv_monitor_if #(.CNT_W(CNT_W)) m();
  freqdiv_monitor #(.CNT_W(CNT_W), .LOCK_CNT(LOCK_CNT), .TOL(TOL), .SYNC_STAGES(SS)) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .m(m)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_zero(input string tag);
    check({tag, " period"}, m.period, 0);
    check({tag, " high"}, m.high, 0);
    check({tag, " stb"}, m.meas_stb, 0);
    check({tag, " valid"}, m.valid, 0);
    check({tag, " locked"}, m.locked, 0);
    check({tag, " timeout"}, m.timeout, 0);
  endtask
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic set_div(input bit v);
    if (v && have_rise) begin
      bit lk;
      hist.push_back(cyc - last_rise);
      lk = hist.size() > LOCK_CNT;
      for (int i = hist.size() - LOCK_CNT; lk && i < hist.size(); i++)
        if (hist[i] - hist[i-1] > TOL || hist[i-1] - hist[i] > TOL) lk = 0;
      exp_p.push_back(cyc - last_rise);
      exp_h.push_back(last_fall - last_rise);
      exp_t.push_back(cyc);
      exp_l.push_back(lk);
    end
    if (v) begin
      have_rise = 1;
      last_rise = cyc;
    end else last_fall = cyc;
    m.clk_div = v;
  endtask
  task automatic drive(input int h, input int l);
    set_div(1);
    wait_cyc(h);
    set_div(0);
    wait_cyc(l);
  endtask
  task automatic close_run();
    drive(6, 6);
    check("stb_drain", exp_p.size(), 0);
  endtask
  task automatic model_restart();
    check("stb_pending", exp_p.size(), 0);
    exp_p.delete();
    exp_h.delete();
    exp_t.delete();
    exp_l.delete();
    hist.delete();
    have_rise = 0;
  endtask
  always @(negedge clk)
    if (m.meas_stb) begin
      if (exp_p.size() == 0) check("stb_unexpected", m.meas_stb, 0);
      else begin
        check("period", m.period, exp_p.pop_front());
        check("high", m.high, exp_h.pop_front());
        check("stb_lat", cyc - exp_t.pop_front(), SS + 1);
        check("valid", m.valid, 1);
        check("locked", m.locked, exp_l.pop_front());
      end
    end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, per, h;
    m.en = 0;
    m.clear = 0;
    m.clk_div = 0;
    wait_cyc(3);
    chk_zero("reset");
    rst_n = 1;
    wait_cyc(2);
    chk_zero("idle");
    m.en = 1;
    wait_cyc(4);
    repeat (8) drive(5, 5);
    close_run();
    check("lock_5x5", m.locked, 1);
    repeat (7) drive(3, 4);
    close_run();
    check("lock_3x4", m.locked, 1);
    repeat (6) begin
      drive(5, 5);
      drive(5, 6);
    end
    check("lock_alt", m.locked, 1);
    drive(7, 7);
    set_div(1);
    wait_cyc(4);
    check("unlock_14", m.locked, 0);
    wait_cyc(1);
    set_div(0);
    wait_cyc(5);
    repeat (6) drive(5, 5);
    close_run();
    check("relock", m.locked, 1);
    while (!m.timeout && cyc - last_rise < 320) wait_cyc(1);
    check("tmo_lat", cyc - last_rise, 255 + SS + 1);
    check("tmo_flag", m.timeout, 1);
    check("tmo_valid", m.valid, 0);
    check("tmo_locked", m.locked, 0);
    model_restart();
    repeat (4) drive(6, 6);
    check("tmo_sticky", m.timeout, 1);
    check("tmo_revalid", m.valid, 1);
    m.clear = 1;
    wait_cyc(1);
    m.clear = 0;
    chk_zero("clear");
    model_restart();
    repeat (6) drive(4, 4);
    close_run();
    check("after_clear_tmo", m.timeout, 0);
    set_div(1);
    wait_cyc(5);
    m.en = 0;
    wait_cyc(1);
    chk_zero("en_off");
    model_restart();
    wait_cyc(3);
    set_div(0);
    wait_cyc(5);
    chk_zero("idle_hold");
    m.en = 1;
    wait_cyc(2);
    repeat (6) drive(4, 5);
    close_run();
    check("lock_reen", m.locked, 1);
    repeat (6) drive(5, 5);
    set_div(1);
    wait_cyc(4);
    check("valid_pre_rst", m.valid, 1);
    #2 rst_n = 0;
    #1 chk_zero("async_rst");
    model_restart();
    set_div(0);
    wait_cyc(3);
    rst_n = 1;
    wait_cyc(2);
    repeat (6) drive(5, 6);
    close_run();
    check("lock_rst", m.locked, 1);
    base = $urandom_range(8, 20);
    repeat (40) begin
      per = base + $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0) per += $urandom_range(2, 5);
      h = $urandom_range(3, per - 3);
      drive(h, per - h);
    end
    close_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
